// File: rtl/change_phase_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : change_phase_counter_pkg
// Description : Shared types and default constants for the change/phase
//               counter and its debounce stage.
// Revision    : 1.0 - initial release
// ============================================================================
package change_phase_counter_pkg;

    localparam int C_DEF_SAMPLE_W   = 4;
    localparam int C_DEF_NUM_PHASES = 8;
    localparam int C_DEF_CNT_W      = 8;
    localparam int C_DEF_MIN_STABLE = 1;
    localparam int C_DEF_PH_W       = $clog2(C_DEF_NUM_PHASES);
    localparam int C_STAB_W         = 8;

    // Change-tracking FSM states
    typedef enum logic [1:0] {
        INIT     = 2'd0,
        TRACK    = 2'd1,
        DEBOUNCE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/change_debounce.sv
`default_nettype none
// ============================================================================
// Module      : change_debounce
// Description : Detects a change of the monitored sample against the
//               reference value and accepts it once it has been stable for
//               MIN_STABLE consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module change_debounce
    import change_phase_counter_pkg::*;
#(
    parameter int SAMPLE_W   = C_DEF_SAMPLE_W,
    parameter int MIN_STABLE = C_DEF_MIN_STABLE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] ref_val,
    output logic                accept,
    output logic [SAMPLE_W-1:0] accepted_value,
    output logic                init_load
);

    localparam logic [C_STAB_W-1:0] C_MIN_STABLE = C_STAB_W'(MIN_STABLE);
    // A single stable cycle means a differing sample is accepted straight
    // from TRACK without passing through DEBOUNCE.
    localparam bit                  C_IMMEDIATE  = (MIN_STABLE == 1);

    state_t              r_state;
    logic [SAMPLE_W-1:0] r_cand;
    logic [C_STAB_W-1:0] r_stab;
    logic [C_STAB_W-1:0] w_stab_inc;
    logic                w_differs;

    assign w_stab_inc     = r_stab + 8'd1;
    assign w_differs      = (sample != ref_val);
    assign accepted_value = sample;
    assign init_load      = (r_state == INIT);

    // Accept decision for the current edge, consumed by the counter stage
    always_comb begin
        accept = 1'b0;
        case (r_state)
            TRACK:    accept = en && w_differs && C_IMMEDIATE;
            DEBOUNCE: accept = en && (sample == r_cand) && (w_stab_inc == C_MIN_STABLE);
            default:  accept = 1'b0;
        endcase
    end

    // State, candidate value and stability count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
            r_cand  <= '0;
            r_stab  <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    r_state <= TRACK;
                end
                TRACK: begin
                    if (en && w_differs && !C_IMMEDIATE) begin
                        r_cand  <= sample;
                        r_stab  <= 8'd1;
                        r_state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!en) begin
                        r_state <= TRACK;
                    end else if (sample == r_cand) begin
                        if (w_stab_inc == C_MIN_STABLE) begin
                            r_state <= TRACK;
                        end else begin
                            r_stab <= w_stab_inc;
                        end
                    end else if (!w_differs) begin
                        // Sample bounced back to the reference: abandon
                        r_state <= TRACK;
                    end else begin
                        // A different new value restarts the stability window
                        r_cand <= sample;
                        r_stab <= 8'd1;
                    end
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/change_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : change_phase_counter
// Description : Counts accepted changes of a monitored sample as a phase
//               index, and counts full phase revolutions with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module change_phase_counter
    import change_phase_counter_pkg::*;
#(
    parameter  int SAMPLE_W   = C_DEF_SAMPLE_W,
    parameter  int NUM_PHASES = C_DEF_NUM_PHASES,
    parameter  int CNT_W      = C_DEF_CNT_W,
    parameter  int MIN_STABLE = C_DEF_MIN_STABLE,
    localparam int PH_W       = $clog2(NUM_PHASES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                clear,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [PH_W-1:0]     phase,
    output logic [CNT_W-1:0]    cycle_count,
    output logic                change_pulse,
    output logic                wrap_pulse,
    output logic                sat
);

    localparam logic [PH_W-1:0]  C_LAST_PHASE = PH_W'(NUM_PHASES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;

    logic [SAMPLE_W-1:0] r_ref;
    logic [PH_W-1:0]     r_phase;
    logic [CNT_W-1:0]    r_cycle_count;
    logic                r_change_pulse;
    logic                r_wrap_pulse;
    logic                r_sat;

    logic                w_accept;
    logic [SAMPLE_W-1:0] w_accepted;
    logic                w_init_load;
    logic                w_at_last;

    change_debounce #(
        .SAMPLE_W   (SAMPLE_W),
        .MIN_STABLE (MIN_STABLE)
    ) u_debounce (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .sample         (sample),
        .ref_val        (r_ref),
        .accept         (w_accept),
        .accepted_value (w_accepted),
        .init_load      (w_init_load)
    );

    assign w_at_last = (r_phase == C_LAST_PHASE);

    // Reference value: captured after reset, then follows each accepted
    // change (clear does not touch it)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ref <= '0;
        end else if (w_init_load) begin
            r_ref <= sample;
        end else if (w_accept) begin
            r_ref <= w_accepted;
        end
    end

    // Phase, revolution count, saturation flag and registered pulses
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_phase        <= '0;
            r_cycle_count  <= '0;
            r_change_pulse <= 1'b0;
            r_wrap_pulse   <= 1'b0;
            r_sat          <= 1'b0;
        end else begin
            r_change_pulse <= w_accept;
            r_wrap_pulse   <= w_accept && w_at_last;
            if (w_accept) begin
                if (w_at_last) begin
                    r_phase <= '0;
                    if (r_cycle_count == C_CNT_MAX) begin
                        r_sat <= 1'b1;
                    end else begin
                        r_cycle_count <= r_cycle_count + 1'b1;
                    end
                end else begin
                    r_phase <= r_phase + 1'b1;
                end
            end
        end
    end

    assign phase        = r_phase;
    assign cycle_count  = r_cycle_count;
    assign change_pulse = r_change_pulse;
    assign wrap_pulse   = r_wrap_pulse;
    assign sat          = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_change_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_phase_counter
// Description : Directed self-checking bench for change_phase_counter using
//               three instances: defaults, MIN_STABLE=3, and a 2-phase /
//               2-bit counter configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_change_phase_counter;

    logic clk = 1'b0;
    logic reset;

    // Default configuration
    logic       d_en, d_clear;
    logic [3:0] d_sample;
    logic [2:0] d_phase;
    logic [7:0] d_cycle_count;
    logic       d_change_pulse, d_wrap_pulse, d_sat;

    // MIN_STABLE = 3
    logic       b_en, b_clear;
    logic [3:0] b_sample;
    logic [2:0] b_phase;
    logic [7:0] b_cycle_count;
    logic       b_change_pulse, b_wrap_pulse, b_sat;

    // NUM_PHASES = 2, CNT_W = 2
    logic       s_en, s_clear;
    logic [3:0] s_sample;
    logic [0:0] s_phase;
    logic [1:0] s_cycle_count;
    logic       s_change_pulse, s_wrap_pulse, s_sat;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    change_phase_counter u_def (
        .clk(clk), .reset(reset), .en(d_en), .clear(d_clear), .sample(d_sample),
        .phase(d_phase), .cycle_count(d_cycle_count), .change_pulse(d_change_pulse),
        .wrap_pulse(d_wrap_pulse), .sat(d_sat)
    );

    change_phase_counter #(.MIN_STABLE(3)) u_deb (
        .clk(clk), .reset(reset), .en(b_en), .clear(b_clear), .sample(b_sample),
        .phase(b_phase), .cycle_count(b_cycle_count), .change_pulse(b_change_pulse),
        .wrap_pulse(b_wrap_pulse), .sat(b_sat)
    );

    change_phase_counter #(.NUM_PHASES(2), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .en(s_en), .clear(s_clear), .sample(s_sample),
        .phase(s_phase), .cycle_count(s_cycle_count), .change_pulse(s_change_pulse),
        .wrap_pulse(s_wrap_pulse), .sat(s_sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        d_en = 1'b1; d_clear = 1'b0; d_sample = 4'd0;
        b_en = 1'b1; b_clear = 1'b0; b_sample = 4'd0;
        s_en = 1'b1; s_clear = 1'b0; s_sample = 4'd0;
        tick();
        tick();

        // Reset state
        check("rst_d_phase", 32'(d_phase), 0);
        check("rst_d_cnt",   32'(d_cycle_count), 0);
        check("rst_d_cp",    32'(d_change_pulse), 0);
        check("rst_d_wp",    32'(d_wrap_pulse), 0);
        check("rst_d_sat",   32'(d_sat), 0);
        check("rst_b_phase", 32'(b_phase), 0);
        check("rst_s_cnt",   32'(s_cycle_count), 0);

        reset = 1'b0;
        tick();                          // INIT captures reference

        // First change with default stability: pulse right after the edge
        d_sample = 4'd3;
        tick();
        check("d_first_cp",    32'(d_change_pulse), 1);
        check("d_first_phase", 32'(d_phase), 1);
        check("d_first_wp",    32'(d_wrap_pulse), 0);
        tick();
        check("d_cp_one_cycle", 32'(d_change_pulse), 0);
        check("d_hold_phase",   32'(d_phase), 1);

        // Seven more distinct changes complete one revolution
        for (int i = 0; i < 7; i++) begin
            d_sample = 4'(4 + i);
            tick();
            check("d_rev_cp",    32'(d_change_pulse), 1);
            check("d_rev_phase", 32'(d_phase), 32'((i + 2) % 8));
            check("d_rev_wp",    32'(d_wrap_pulse), (i == 6) ? 1 : 0);
        end
        check("d_rev_cnt", 32'(d_cycle_count), 1);
        tick();
        check("d_wp_one_cycle", 32'(d_wrap_pulse), 0);

        // Disabled: toggling sample does nothing, ends on the reference value
        d_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            d_sample = (i % 2 == 0) ? 4'd11 : 4'd10;
            tick();
            check("d_en0_cp", 32'(d_change_pulse), 0);
            check("d_en0_wp", 32'(d_wrap_pulse), 0);
        end
        check("d_en0_phase", 32'(d_phase), 0);
        check("d_en0_cnt",   32'(d_cycle_count), 1);
        d_en = 1'b1;
        tick();
        check("d_reen_cp",    32'(d_change_pulse), 0);
        check("d_reen_phase", 32'(d_phase), 0);

        // Clear coincident with accept: counters zero, reference still moves
        d_sample = 4'd1;
        d_clear  = 1'b1;
        tick();
        check("d_clr_phase", 32'(d_phase), 0);
        check("d_clr_cp",    32'(d_change_pulse), 0);
        check("d_clr_cnt",   32'(d_cycle_count), 0);
        d_clear = 1'b0;
        tick();
        check("d_clr_refupd_cp", 32'(d_change_pulse), 0);
        d_sample = 4'd2;
        tick();
        check("d_post_clr_cp",    32'(d_change_pulse), 1);
        check("d_post_clr_phase", 32'(d_phase), 1);

        // MIN_STABLE=3: establish reference 5, three-cycle latency
        b_sample = 4'd5;
        tick();
        check("b_lat_c1", 32'(b_change_pulse), 0);
        tick();
        check("b_lat_c2", 32'(b_change_pulse), 0);
        tick();
        check("b_lat_c3_cp",    32'(b_change_pulse), 1);
        check("b_lat_c3_phase", 32'(b_phase), 1);
        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
        check("b_clr_phase", 32'(b_phase), 0);

        // 6 for two cycles then back to 5: aborted, no pulse
        b_sample = 4'd6;
        tick();
        check("b_abort_c1", 32'(b_change_pulse), 0);
        tick();
        check("b_abort_c2", 32'(b_change_pulse), 0);
        b_sample = 4'd5;
        tick();
        check("b_abort_c3", 32'(b_change_pulse), 0);
        tick();
        check("b_abort_c4",    32'(b_change_pulse), 0);
        check("b_abort_phase", 32'(b_phase), 0);

        // 6 held for three cycles: accepted
        b_sample = 4'd6;
        tick();
        check("b_acc_c1", 32'(b_change_pulse), 0);
        tick();
        check("b_acc_c2", 32'(b_change_pulse), 0);
        tick();
        check("b_acc_c3_cp",    32'(b_change_pulse), 1);
        check("b_acc_c3_phase", 32'(b_phase), 1);

        // Saturation: 2 phases, 2-bit counter, 8 changes
        for (int i = 0; i < 8; i++) begin
            s_sample = (i % 2 == 0) ? 4'd1 : 4'd2;
            tick();
            check("s_cp",  32'(s_change_pulse), 1);
            check("s_cnt", 32'(s_cycle_count), ((i + 1) / 2 > 3) ? 3 : 32'((i + 1) / 2));
        end
        check("s_sat_flag",  32'(s_sat), 1);
        check("s_sat_phase", 32'(s_phase), 0);
        tick();
        check("s_sat_sticky", 32'(s_sat), 1);
        s_clear = 1'b1;
        tick();
        s_clear = 1'b0;
        check("s_clr_cnt",   32'(s_cycle_count), 0);
        check("s_clr_sat",   32'(s_sat), 0);
        check("s_clr_phase", 32'(s_phase), 0);

        // Reset in the middle of a debounce window discards the candidate
        b_sample = 4'd9;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("b_rst_cp",    32'(b_change_pulse), 0);
        check("b_rst_phase", 32'(b_phase), 0);
        reset = 1'b0;
        tick();                          // INIT reloads reference with 9
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b_rst_quiet_cp", 32'(b_change_pulse), 0);
        end
        check("b_rst_quiet_phase", 32'(b_phase), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
